// File: rtl/mul_pkg.sv
// Shared types and sizing for the radix-4 Booth multiply sequencer.
package mul_pkg;

    localparam int BOOTH_DIGITS = 17;
    localparam int EXT_W        = 33;
    localparam int PP_W         = 34;
    localparam int ACC_W        = 66;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // CALC cycles needed to retire all Booth digits at dpc digits per cycle.
    function automatic int calc_cycles(input int dpc);
        return (BOOTH_DIGITS + dpc - 1) / dpc;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Operand request and product response channels of the multiply sequencer.
interface mul_seq_ctrl_if;
    import mul_pkg::*;

    // Both channels: a transfer happens on a rising edge where valid && ready;
    // the sender holds valid and payload stable until that edge.
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    modport master (
        output in_valid, in_signed, in_a, in_b, out_ready,
        input  in_ready, out_valid, res_hi, res_lo
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, out_ready,
        output in_ready, out_valid, res_hi, res_lo
    );

endinterface

// File: rtl/mul_booth_pp.sv
// One radix-4 Booth partial product: selects 0, +-X or +-2X from a multiplier bit triple.
module mul_booth_pp
    import mul_pkg::*;
(
    input  logic [2:0]       triple,
    input  logic [EXT_W-1:0] x,
    output logic [PP_W-1:0]  pp
);

    logic [PP_W-1:0] x1;
    logic [PP_W-1:0] x2;

    // X is at most 33 signed bits, so +-2X always fits in 34.
    assign x1 = {x[EXT_W-1], x};
    assign x2 = {x, 1'b0};

    always_comb begin
        pp = '0;
        case (triple)
            3'b001, 3'b010: pp = x1;
            3'b011:         pp = x2;
            3'b100:         pp = -x2;
            3'b101, 3'b110: pp = -x1;
            default:        pp = '0;
        endcase
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative radix-4 Booth multiplier for MULT/MULTU: DPC digits per CALC cycle,
// fixed latency of calc_cycles(DPC) edges from accept to product valid.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int DPC = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    mul_seq_ctrl_if.slave bus,
    output logic          busy,
    output state_t        state_dbg
);

    localparam int C = calc_cycles(DPC);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [EXT_W-1:0]  x_q, x_d, y_q, y_d;
    logic              out_valid_q, out_valid_d;
    logic [63:0]       res_q, res_d;
    logic              in_ready;
    logic              accept;
    logic [EXT_W+1:0]  y_win;
    logic [ACC_W-1:0]  pp_term [DPC];

    // Bit j of y_win is Y[j-1]: the implicit Y[-1]=0 at the bottom, Y[32] repeated on top.
    assign y_win = {y_q[EXT_W-1], y_q, 1'b0};

    for (genvar d = 0; d < DPC; d++) begin : g_pp
        logic [7:0]      digit;
        logic [2:0]      triple;
        logic [PP_W-1:0] pp;

        assign digit  = 8'(int'(cnt_q) * DPC + d);
        assign triple = 3'(y_win >> {digit, 1'b0});

        mul_booth_pp u_pp (
            .triple (triple),
            .x      (x_q),
            .pp     (pp)
        );

        // Digits past the last one (possible when DPC does not divide 17) add nothing.
        assign pp_term[d] = (digit < 8'(BOOTH_DIGITS))
                          ? ({{(ACC_W-PP_W){pp[PP_W-1]}}, pp} << {digit, 1'b0})
                          : '0;
    end

    always_comb begin
        acc_sum = acc_q;
        for (int d = 0; d < DPC; d++) begin
            acc_sum = acc_sum + pp_term[d];
        end
    end

    assign in_ready = !flush && (state_q == IDLE || (state_q == DONE && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        x_d         = x_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        x_d         = {bus.in_signed & bus.in_a[31], bus.in_a};
                        y_d         = {bus.in_signed & bus.in_b[31], bus.in_b};
                        acc_d       = '0;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        state_d     = CALC;
                    end else if (state_q == DONE && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                CALC: begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(C - 1)) begin
                        res_d       = acc_sum[63:0];
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.res_hi    = res_q[63:32];
    assign bus.res_lo    = res_q[31:0];
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a DPC=1 and a DPC=4 instance share one stimulus port set,
// steered by sel; products are checked from a scoreboard queue by a monitor.
module tb_mul_seq_ctrl;
    import mul_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        sel;
    logic        in_valid;
    logic        in_signed;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;

    logic        busy1, busy4;
    state_t      st1, st4;
    logic        m_in_ready, m_out_valid, m_busy;
    logic [31:0] m_hi, m_lo;
    state_t      m_state;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    vec_t dir4 [6] = '{
        '{32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E_242D2080},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001},
        '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000},
        '{32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFEB},
        '{32'h00000007, 32'hFFFFFFFD, 1'b0, 64'h00000006_FFFFFFEB},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001}
    };

    mul_seq_ctrl_if bus1 ();
    mul_seq_ctrl_if bus4 ();

    assign bus1.in_valid  = in_valid && !sel;
    assign bus1.in_signed = in_signed;
    assign bus1.in_a      = in_a;
    assign bus1.in_b      = in_b;
    assign bus1.out_ready = sel ? 1'b1 : out_ready;
    assign bus4.in_valid  = in_valid && sel;
    assign bus4.in_signed = in_signed;
    assign bus4.in_a      = in_a;
    assign bus4.in_b      = in_b;
    assign bus4.out_ready = sel ? out_ready : 1'b1;

    mul_seq_ctrl #(.DPC(1)) u_dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush && !sel),
        .bus       (bus1),
        .busy      (busy1),
        .state_dbg (st1)
    );

    mul_seq_ctrl #(.DPC(4)) u_dut4 (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush && sel),
        .bus       (bus4),
        .busy      (busy4),
        .state_dbg (st4)
    );

    assign m_in_ready  = sel ? bus4.in_ready  : bus1.in_ready;
    assign m_out_valid = sel ? bus4.out_valid : bus1.out_valid;
    assign m_hi        = sel ? bus4.res_hi    : bus1.res_hi;
    assign m_lo        = sel ? bus4.res_lo    : bus1.res_lo;
    assign m_busy      = sel ? busy4          : busy1;
    assign m_state     = sel ? st4            : st1;

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: every product handshake is compared with the oldest expected value.
    initial begin
        forever begin
            @(negedge clk);
            if (m_out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got %h, expected no result", {m_hi, m_lo});
                end else begin
                    check("product", {m_hi, m_lo}, exp_q.pop_front());
                end
            end
        end
    end

    // Driver tasks
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] p);
        int n = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        @(negedge clk);
        while (!m_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected high", n);
        end else begin
            exp_q.push_back(p);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_a      = $urandom;
        in_b      = $urandom;
        in_signed = 1'($urandom_range(0, 1));
    endtask

    // Returns at the negedge where out_valid is first seen; edges counted from the accept edge.
    task automatic wait_result(input int lat, input string name);
        int edges = 0;
        @(negedge clk);
        while (!m_out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check(name, 64'(edges), 64'(lat));
    endtask

    task automatic expect_silent(input int n, input string name);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (m_out_valid) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [63:0] sa, sb;
        logic [31:0]        ra, rb;
        logic               rs;
        logic [63:0]        rp;

        resetn    = 1'b0;
        flush     = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res",   {m_hi, m_lo}, 64'd0);
        check("rst_flags", 64'({m_out_valid, m_busy, m_in_ready}), 64'b001);
        check("rst_state", 64'(m_state), 64'(IDLE));
        step();
        resetn = 1'b1;
        step();

        // Full-latency unsigned worst case on DPC=1
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        wait_result(17, "lat_ffff");
        step();

        // Reset during the fifth CALC cycle
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        repeat (4) step();
        check("busy_mid_calc", 64'({m_busy, m_state}), 64'({1'b1, CALC}));
        resetn = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("midrst_res",   {m_hi, m_lo}, 64'd0);
        check("midrst_flags", 64'({m_out_valid, m_busy}), 64'd0);
        check("midrst_state", 64'(m_state), 64'(IDLE));
        step();
        resetn = 1'b1;
        expect_silent(25, "midrst_no_result");
        step();

        // Signed and unsigned products on DPC=1
        for (int i = 1; i < 5; i++) begin
            issue(dir4[i].a, dir4[i].b, dir4[i].s, dir4[i].p);
            wait_result(17, "lat_dpc1");
            step();
        end

        // Backpressure then back-to-back accept
        out_ready = 1'b0;
        issue(32'd6, 32'd7, 1'b0, 64'd42);
        wait_result(17, "lat_bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_res",   {m_hi, m_lo}, 64'd42);
            check("bp_flags", 64'({m_out_valid, m_in_ready}), 64'b10);
            @(negedge clk);
        end
        step();
        out_ready = 1'b1;
        issue(32'd3, 32'd5, 1'b0, 64'd15);
        wait_result(17, "lat_b2b");
        step();

        // Flush mid-CALC at cnt=8
        issue(32'd9, 32'd9, 1'b0, 64'd81);
        repeat (8) step();
        flush = 1'b1;
        void'(exp_q.pop_back());
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_calc_state", 64'({m_busy, m_state}), 64'({1'b0, IDLE}));
        expect_silent(25, "flush_calc_no_result");
        step();
        issue(32'd2, 32'd3, 1'b1, 64'd6);
        wait_result(17, "lat_after_flush");
        step();

        // Flush in DONE with a request pending
        out_ready = 1'b0;
        issue(32'd4, 32'd4, 1'b0, 64'd16);
        wait_result(17, "lat_flush_done");
        void'(exp_q.pop_back());
        step();
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'd5;
        in_b      = 32'd5;
        @(negedge clk);
        check("flush_in_ready", 64'(m_in_ready), 64'd0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_done_flags", 64'({m_out_valid, m_busy}), 64'd0);
        check("flush_done_state", 64'(m_state), 64'(IDLE));
        expect_silent(20, "flush_done_no_result");
        step();

        // DPC=4 instance: directed vectors then random reference compare
        sel = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            issue(dir4[i].a, dir4[i].b, dir4[i].s, dir4[i].p);
            wait_result(5, "lat_dpc4");
            step();
        end
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'($urandom_range(0, 1) ? 31'h7FFFFFFF : 31'h0)};
            if ($urandom_range(0, 3) == 0) rb = {rb[31], 31'($urandom_range(0, 1) ? 31'h7FFFFFFF : 31'h0)};
            sa = $signed(ra);
            sb = $signed(rb);
            rp = rs ? 64'(sa * sb) : ({32'd0, ra} * {32'd0, rb});
            issue(ra, rb, rs, rp);
            wait_result(5, "lat_rand");
            step();
        end

        repeat (5) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
